axi4_stream_to_axi4: RTL and testbench



---
 rtl/axi4_stream_to_axi4_pkg.sv | 27 ++
 rtl/axi4_stream_to_axi4_buf.sv | 41 ++++
 rtl/axi4_stream_to_axi4.sv | 210 +++++++++++++++++++++
 tb/tb_axi4_stream_to_axi4.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_stream_to_axi4_pkg.sv
// rtl/axi4_stream_to_axi4_pkg.sv - shared types and constants for the stream-to-AXI4 packet writer
package axi4_stream_to_axi4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC_BURST,
    ST_COLLECT,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } wr_state_e;

  localparam int BOUNDARY_4K   = 4096;
  localparam int MAX_BURST_LEN = 256;

  // Beats that fit before the next 4 KB page, capped at the AXI4 INCR limit.
  function automatic logic [8:0] calc_burst_max(input logic [11:0] page_ofs, input int beat_shift);
    logic [12:0] room;
    room = 13'(BOUNDARY_4K) - {1'b0, page_ofs};
    room = room >> beat_shift;
    if (room > 13'(MAX_BURST_LEN)) begin
      return 9'(MAX_BURST_LEN);
    end
    return room[8:0];
  endfunction

endpackage

// File: rtl/axi4_stream_to_axi4_buf.sv
// rtl/axi4_stream_to_axi4_buf.sv - one-burst FWFT beat buffer (simple dual-port RAM, async read)
module axi4_wr_burst_buf
  import axi4_stream_to_axi4_pkg::*;
#(
  parameter int WIDTH = 72
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [8:0]       count
);

  logic [WIDTH-1:0] mem [0:MAX_BURST_LEN-1];
  logic [7:0]       wr_ptr;
  logic [7:0]       rd_ptr;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 8'd1;
      if (pop)  rd_ptr <= rd_ptr + 8'd1;
      count <= count + 9'(push) - 9'(pop);
    end
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/axi4_stream_to_axi4.sv
// rtl/axi4_stream_to_axi4.sv - writes one AXI4-Stream packet to memory as 4 KB-safe AXI4 bursts
module axi4_stream_to_axi4
  import axi4_stream_to_axi4_pkg::*;
#(
  parameter int DATA_WIDTH         = 64,
  parameter int ADDR_WIDTH         = 32,
  parameter int ID_WIDTH           = 1,
  parameter int AWUSER_WIDTH       = 1,
  parameter int WUSER_WIDTH        = 1,
  parameter int ARUSER_WIDTH       = 1,
  parameter int MAX_PKT_SIZE_B     = 2048,
  parameter int MAX_PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B*4)
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [ADDR_WIDTH-1:0]         addr_i,
  input  logic                          wr_stb_i,
  output logic                          busy_o,
  output logic                          pkt_done_o,
  output logic [MAX_PKT_SIZE_WIDTH:0]   pkt_size_o,
  output logic                          pkt_err_o,
  input  logic [DATA_WIDTH-1:0]         pkt_tdata,
  input  logic [DATA_WIDTH/8-1:0]       pkt_tkeep,
  input  logic                          pkt_tlast,
  input  logic                          pkt_tvalid,
  output logic                          pkt_tready,
  output logic [ID_WIDTH-1:0]           mem_awid,
  output logic [ADDR_WIDTH-1:0]         mem_awaddr,
  output logic [7:0]                    mem_awlen,
  output logic [2:0]                    mem_awsize,
  output logic [1:0]                    mem_awburst,
  output logic [AWUSER_WIDTH-1:0]       mem_awuser,
  output logic                          mem_awvalid,
  input  logic                          mem_awready,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  output logic [DATA_WIDTH/8-1:0]       mem_wstrb,
  output logic                          mem_wlast,
  output logic [WUSER_WIDTH-1:0]        mem_wuser,
  output logic                          mem_wvalid,
  input  logic                          mem_wready,
  input  logic [1:0]                    mem_bresp,
  input  logic                          mem_bvalid,
  output logic                          mem_bready,
  output logic [ID_WIDTH-1:0]           mem_arid,
  output logic [ADDR_WIDTH-1:0]         mem_araddr,
  output logic [7:0]                    mem_arlen,
  output logic [2:0]                    mem_arsize,
  output logic [1:0]                    mem_arburst,
  output logic [ARUSER_WIDTH-1:0]       mem_aruser,
  output logic                          mem_arvalid,
  output logic                          mem_rready
);

  localparam int DW_B       = DATA_WIDTH / 8;
  localparam int SIZE_SHIFT = $clog2(DW_B);
  localparam int BUF_W      = DATA_WIDTH + DW_B;
  localparam int CNT_W      = MAX_PKT_SIZE_WIDTH + 1;

  wr_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q;
  logic [8:0]            beat_cnt_q, burst_max_q;
  logic [CNT_W-1:0]      byte_cnt_q, pkt_size_q, keep_bytes;
  logic                  last_burst_q, pkt_err_acc_q, pkt_err_q, pkt_done_q;
  logic                  awvalid_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]            awlen_q;
  logic                  wvalid_q, wlast_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DW_B-1:0]       wstrb_q;
  logic [BUF_W-1:0]      buf_rd_data;
  logic [8:0]            buf_count;
  logic                  start, beat_acc, beat_close, aw_hs, w_hs, b_hs, w_load;

  assign start      = (state_q == ST_IDLE) && wr_stb_i;
  assign pkt_tready = (state_q == ST_COLLECT) && (beat_cnt_q < burst_max_q);
  assign beat_acc   = pkt_tvalid && pkt_tready;
  assign beat_close = beat_acc && (pkt_tlast || (beat_cnt_q + 9'd1 == burst_max_q));
  assign aw_hs      = (state_q == ST_ADDR) && awvalid_q && mem_awready;
  assign w_hs       = (state_q == ST_DATA) && wvalid_q && mem_wready;
  assign b_hs       = (state_q == ST_RESP) && mem_bvalid;
  // Prefetch the first beat on the AW handshake so wvalid is up in the first DATA cycle.
  assign w_load     = aw_hs || (w_hs && !wlast_q);

  axi4_wr_burst_buf #(.WIDTH(BUF_W)) u_buf (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clear     (start),
    .push      (beat_acc),
    .push_data ({pkt_tkeep, pkt_tdata}),
    .pop       (w_load),
    .pop_data  (buf_rd_data),
    .count     (buf_count)
  );

  always_comb begin
    keep_bytes = '0;
    for (int i = 0; i < DW_B; i++) begin
      keep_bytes = keep_bytes + CNT_W'(pkt_tkeep[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (wr_stb_i) state_d = ST_CALC_BURST;
      ST_CALC_BURST: state_d = ST_COLLECT;
      ST_COLLECT:    if (beat_close) state_d = ST_ADDR;
      ST_ADDR:       if (aw_hs) state_d = ST_DATA;
      ST_DATA:       if (w_hs && wlast_q) state_d = ST_RESP;
      ST_RESP:       if (b_hs) state_d = last_burst_q ? ST_IDLE : ST_CALC_BURST;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cur_addr_q    <= '0;
      beat_cnt_q    <= '0;
      burst_max_q   <= '0;
      byte_cnt_q    <= '0;
      pkt_size_q    <= '0;
      last_burst_q  <= 1'b0;
      pkt_err_acc_q <= 1'b0;
      pkt_err_q     <= 1'b0;
      pkt_done_q    <= 1'b0;
      awvalid_q     <= 1'b0;
      awaddr_q      <= '0;
      awlen_q       <= '0;
      wvalid_q      <= 1'b0;
      wlast_q       <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
    end else begin
      pkt_done_q <= 1'b0;
      if (start) begin
        cur_addr_q    <= addr_i & ~ADDR_WIDTH'(DW_B - 1);
        byte_cnt_q    <= '0;
        pkt_err_acc_q <= 1'b0;
        beat_cnt_q    <= '0;
      end
      if (state_q == ST_CALC_BURST) begin
        burst_max_q <= calc_burst_max(cur_addr_q[11:0], SIZE_SHIFT);
      end
      if (beat_acc) begin
        beat_cnt_q <= beat_cnt_q + 9'd1;
        byte_cnt_q <= byte_cnt_q + keep_bytes;
      end
      // The old beat count equals the new count minus one, i.e. the AXI awlen.
      if (beat_close) begin
        last_burst_q <= pkt_tlast;
        awvalid_q    <= 1'b1;
        awaddr_q     <= cur_addr_q;
        awlen_q      <= beat_cnt_q[7:0];
      end
      if (aw_hs) awvalid_q <= 1'b0;
      if (w_load) begin
        wvalid_q             <= 1'b1;
        {wstrb_q, wdata_q}   <= buf_rd_data;
        wlast_q              <= (buf_count == 9'd1);
      end else if (w_hs) begin
        wvalid_q <= 1'b0;
        wlast_q  <= 1'b0;
      end
      if (b_hs) begin
        pkt_err_acc_q <= pkt_err_acc_q | (mem_bresp != 2'b00);
        cur_addr_q    <= cur_addr_q + (ADDR_WIDTH'(beat_cnt_q) << SIZE_SHIFT);
        beat_cnt_q    <= '0;
        if (last_burst_q) begin
          pkt_done_q <= 1'b1;
          pkt_size_q <= byte_cnt_q;
          pkt_err_q  <= pkt_err_acc_q | (mem_bresp != 2'b00);
        end
      end
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign pkt_done_o  = pkt_done_q;
  assign pkt_size_o  = pkt_size_q;
  assign pkt_err_o   = pkt_err_q;

  assign mem_awid    = '0;
  assign mem_awaddr  = awaddr_q;
  assign mem_awlen   = awlen_q;
  assign mem_awsize  = 3'(SIZE_SHIFT);
  assign mem_awburst = 2'b01;
  assign mem_awuser  = '0;
  assign mem_awvalid = awvalid_q;
  assign mem_wdata   = wdata_q;
  assign mem_wstrb   = wstrb_q;
  assign mem_wlast   = wlast_q;
  assign mem_wuser   = '0;
  assign mem_wvalid  = wvalid_q;
  assign mem_bready  = (state_q == ST_RESP);

  assign mem_arid    = '0;
  assign mem_araddr  = '0;
  assign mem_arlen   = '0;
  assign mem_arsize  = '0;
  assign mem_arburst = '0;
  assign mem_aruser  = '0;
  assign mem_arvalid = 1'b0;
  assign mem_rready  = 1'b1;

endmodule

// File: tb/tb_axi4_stream_to_axi4.sv
// tb/tb_axi4_stream_to_axi4.sv - directed self-checking bench for axi4_stream_to_axi4
module tb_axi4_stream_to_axi4;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        wr_stb_i = 1'b0;
  logic        busy_o, pkt_done_o, pkt_err_o;
  logic [13:0] pkt_size_o;
  logic [63:0] pkt_tdata = '0;
  logic [7:0]  pkt_tkeep = '0;
  logic        pkt_tlast = 1'b0, pkt_tvalid = 1'b0, pkt_tready;
  logic [0:0]  mem_awid, mem_awuser, mem_wuser, mem_arid, mem_aruser;
  logic [31:0] mem_awaddr, mem_araddr;
  logic [7:0]  mem_awlen, mem_arlen, mem_wstrb;
  logic [2:0]  mem_awsize, mem_arsize;
  logic [1:0]  mem_awburst, mem_arburst;
  logic        mem_awvalid, mem_awready = 1'b0;
  logic [63:0] mem_wdata;
  logic        mem_wlast, mem_wvalid, mem_wready = 1'b0;
  logic [1:0]  mem_bresp = 2'b00;
  logic        mem_bvalid = 1'b0, mem_bready, mem_arvalid, mem_rready;

  axi4_stream_to_axi4 dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .addr_i(addr_i), .wr_stb_i(wr_stb_i),
    .busy_o(busy_o), .pkt_done_o(pkt_done_o), .pkt_size_o(pkt_size_o), .pkt_err_o(pkt_err_o),
    .pkt_tdata(pkt_tdata), .pkt_tkeep(pkt_tkeep), .pkt_tlast(pkt_tlast),
    .pkt_tvalid(pkt_tvalid), .pkt_tready(pkt_tready),
    .mem_awid(mem_awid), .mem_awaddr(mem_awaddr), .mem_awlen(mem_awlen), .mem_awsize(mem_awsize),
    .mem_awburst(mem_awburst), .mem_awuser(mem_awuser), .mem_awvalid(mem_awvalid),
    .mem_awready(mem_awready), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_wlast(mem_wlast), .mem_wuser(mem_wuser), .mem_wvalid(mem_wvalid),
    .mem_wready(mem_wready), .mem_bresp(mem_bresp), .mem_bvalid(mem_bvalid),
    .mem_bready(mem_bready), .mem_arid(mem_arid), .mem_araddr(mem_araddr),
    .mem_arlen(mem_arlen), .mem_arsize(mem_arsize), .mem_arburst(mem_arburst),
    .mem_aruser(mem_aruser), .mem_arvalid(mem_arvalid), .mem_rready(mem_rready)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave behaviour knobs: w_mode 0 = always ready, 1 = toggle, 2 = held low.
  int aw_delay  = 0;
  int w_mode    = 0;
  int err_burst = -1;
  int aw_cnt    = 0;

  logic [39:0] aw_q[$];
  logic [63:0] wd_q[$];
  logic [7:0]  ws_q[$];
  logic        wl_q[$];
  int          b_cnt = 0, done_cnt = 0, stab_viol = 0, tready_viol = 0;

  initial begin
    forever begin
      @(posedge clk_i); #1;
      if (mem_awvalid) begin
        if (aw_cnt >= aw_delay) mem_awready = 1'b1;
        else begin mem_awready = 1'b0; aw_cnt++; end
      end else begin
        mem_awready = 1'b0;
        aw_cnt = 0;
      end
      case (w_mode)
        1:       mem_wready = ~mem_wready;
        2:       mem_wready = 1'b0;
        default: mem_wready = 1'b1;
      endcase
      mem_bvalid = mem_bready;
      mem_bresp  = (mem_bready && b_cnt == err_burst) ? 2'b10 : 2'b00;
    end
  end

  logic        aw_stall = 1'b0, w_stall = 1'b0;
  logic [39:0] aw_hold;
  logic [72:0] w_hold;

  initial begin
    forever begin
      @(negedge clk_i);
      if (mem_awvalid && mem_awready) aw_q.push_back({mem_awaddr, mem_awlen});
      if (mem_wvalid && mem_wready) begin
        wd_q.push_back(mem_wdata);
        ws_q.push_back(mem_wstrb);
        wl_q.push_back(mem_wlast);
      end
      if (mem_bvalid && mem_bready) b_cnt++;
      if (pkt_done_o) done_cnt++;
      if (pkt_tready && (mem_awvalid || mem_wvalid || mem_bready || !busy_o)) tready_viol++;
      if (!rst_n_i) begin
        aw_stall = 1'b0;
        w_stall  = 1'b0;
      end else begin
        if (aw_stall && (!mem_awvalid || {mem_awaddr, mem_awlen} != aw_hold)) stab_viol++;
        if (w_stall && (!mem_wvalid || {mem_wdata, mem_wstrb, mem_wlast} != w_hold)) stab_viol++;
        aw_stall = mem_awvalid && !mem_awready;
        w_stall  = mem_wvalid && !mem_wready;
        aw_hold  = {mem_awaddr, mem_awlen};
        w_hold   = {mem_wdata, mem_wstrb, mem_wlast};
      end
    end
  end

  task automatic send_pkt(input int n, input logic [7:0] last_keep, input bit gaps,
                          input int stb_at, input logic [63:0] seed);
    int guard;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        pkt_tvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
      end
      if (i == stb_at) begin wr_stb_i = 1'b1; addr_i = 32'h5000; end
      else wr_stb_i = 1'b0;
      pkt_tvalid = 1'b1;
      pkt_tdata  = seed + 64'(i);
      pkt_tkeep  = (i == n - 1) ? last_keep : 8'hFF;
      pkt_tlast  = (i == n - 1);
      @(negedge clk_i);
      guard = 0;
      while (!pkt_tready && guard < 2000) begin @(negedge clk_i); guard++; end
      if (!pkt_tready) begin
        check("tready_timeout", 0, 1);
        pkt_tvalid = 1'b0;
        wr_stb_i   = 1'b0;
        return;
      end
      @(posedge clk_i); #1;
    end
    pkt_tvalid = 1'b0;
    pkt_tlast  = 1'b0;
    wr_stb_i   = 1'b0;
  endtask

  task automatic start_pkt(input logic [31:0] addr);
    addr_i = addr;
    wr_stb_i = 1'b1;
    @(posedge clk_i); #1;
    wr_stb_i = 1'b0;
  endtask

  task automatic run_pkt(input string name, input logic [31:0] addr, input int n,
                         input logic [7:0] last_keep, input bit gaps, input int stb_at,
                         input logic [63:0] seed, input int exp_bursts,
                         input logic [31:0] a0, input logic [7:0] l0,
                         input logic [31:0] a1, input logic [7:0] l1,
                         input int exp_size, input logic exp_err);
    int guard, mism;
    logic got_done, busy_at_done;
    logic [13:0] size_at_done;
    logic err_at_done;
    aw_q.delete(); wd_q.delete(); ws_q.delete(); wl_q.delete();
    b_cnt = 0; done_cnt = 0;
    start_pkt(addr);
    check({name, "/busy_after_stb"}, busy_o, 1);
    send_pkt(n, last_keep, gaps, stb_at, seed);
    guard = 0; got_done = 1'b0;
    size_at_done = '0; err_at_done = 1'b0; busy_at_done = 1'b1;
    while (!got_done && guard < 5000) begin
      @(negedge clk_i);
      guard++;
      if (pkt_done_o) begin
        got_done = 1'b1;
        size_at_done = pkt_size_o;
        err_at_done = pkt_err_o;
        busy_at_done = busy_o;
      end
    end
    check({name, "/done_seen"}, got_done, 1);
    check({name, "/pkt_size"}, size_at_done, exp_size);
    check({name, "/pkt_err"}, err_at_done, exp_err);
    check({name, "/busy_at_done"}, busy_at_done, 0);
    repeat (3) @(negedge clk_i);
    check({name, "/done_pulses"}, done_cnt, 1);
    check({name, "/busy_after"}, busy_o, 0);
    check({name, "/aw_count"}, aw_q.size(), exp_bursts);
    if (aw_q.size() > 0) begin
      check({name, "/aw0_addr"}, aw_q[0][39:8], a0);
      check({name, "/aw0_len"}, aw_q[0][7:0], l0);
    end
    if (exp_bursts > 1 && aw_q.size() > 1) begin
      check({name, "/aw1_addr"}, aw_q[1][39:8], a1);
      check({name, "/aw1_len"}, aw_q[1][7:0], l1);
    end
    check({name, "/w_count"}, wd_q.size(), n);
    mism = 0;
    for (int i = 0; i < n && i < wd_q.size(); i++) begin
      if (wd_q[i] !== seed + 64'(i)) mism++;
      if (ws_q[i] !== ((i == n - 1) ? last_keep : 8'hFF)) mism++;
      if (wl_q[i] !== ((i == int'(l0)) || (i == n - 1))) mism++;
    end
    check({name, "/w_beat_mism"}, mism, 0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    int guard;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst/busy", busy_o, 0);
    check("rst/done", pkt_done_o, 0);
    check("rst/size", pkt_size_o, 0);
    check("rst/err", pkt_err_o, 0);
    check("rst/awvalid", mem_awvalid, 0);
    check("rst/wvalid", mem_wvalid, 0);
    check("rst/tready", pkt_tready, 0);
    check("rst/awaddr", mem_awaddr, 0);
    check("rst/awlen", mem_awlen, 0);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    run_pkt("t1_basic", 32'h1000, 16, 8'h0F, 0, -1, 64'h1100_0000, 1,
            32'h1000, 8'd15, 32'h0, 8'd0, 124, 1'b0);
    check("t1/awsize", mem_awsize, 3);
    check("t1/awburst", mem_awburst, 1);
    run_pkt("t2_300", 32'h0, 300, 8'hFF, 0, -1, 64'h2200_0000, 2,
            32'h0, 8'd255, 32'h800, 8'd43, 2400, 1'b0);
    run_pkt("t3_4k", 32'h0F80, 32, 8'hFF, 0, -1, 64'h3300_0000, 2,
            32'h0F80, 8'd15, 32'h1000, 8'd15, 256, 1'b0);
    run_pkt("t4_unal", 32'h1003, 5, 8'h01, 0, 2, 64'h4400_0000, 1,
            32'h1000, 8'd4, 32'h0, 8'd0, 33, 1'b0);
    aw_delay = 5; w_mode = 1;
    run_pkt("t5_bp", 32'h4000, 20, 8'h3C, 1, -1, 64'h5500_0000, 1,
            32'h4000, 8'd19, 32'h0, 8'd0, 156, 1'b0);
    aw_delay = 0; w_mode = 0;
    run_pkt("t6_keep0", 32'h6000, 3, 8'h00, 0, -1, 64'h6600_0000, 1,
            32'h6000, 8'd2, 32'h0, 8'd0, 16, 1'b0);
    err_burst = 1;
    run_pkt("t7_slverr", 32'h1F80, 32, 8'hFF, 0, -1, 64'h7700_0000, 2,
            32'h1F80, 8'd15, 32'h2000, 8'd15, 256, 1'b1);
    err_burst = -1;

    w_mode = 2;
    start_pkt(32'h2000);
    send_pkt(4, 8'hFF, 0, -1, 64'h8800_0000);
    guard = 0;
    @(negedge clk_i);
    while (!mem_wvalid && guard < 100) begin @(negedge clk_i); guard++; end
    check("t8/wvalid_before_rst", mem_wvalid, 1);
    @(posedge clk_i); #1;
    rst_n_i = 1'b0;
    @(posedge clk_i); #1;
    check("t8/wvalid_after_rst", mem_wvalid, 0);
    check("t8/busy_after_rst", busy_o, 0);
    check("t8/awvalid_after_rst", mem_awvalid, 0);
    rst_n_i = 1'b1;
    w_mode = 0;
    @(posedge clk_i); #1;
    run_pkt("t8_post_rst", 32'h3000, 8, 8'hFF, 0, -1, 64'h9900_0000, 1,
            32'h3000, 8'd7, 32'h0, 8'd0, 64, 1'b0);

    check("stall_stability_viol", stab_viol, 0);
    check("tready_outside_collect", tready_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
